// File: rtl/frame_asm_pkg.sv
// Shared types and constants for the frame word assembler.
//   state_e          : assembler FSM states (IDLE, COLLECT)
//   SYNC_NIBBLE_DEF  : default sync nibble expected in the first byte's high nibble
//   TAIL_PATTERN_DEF : default tail pattern expected in the word's low 16 bits
//   STAT_W           : width of the good/bad frame statistics counters
//   sat_inc()        : saturating increment for the statistics counters
package frame_asm_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam logic [3:0]  SYNC_NIBBLE_DEF  = 4'hA;
    localparam logic [15:0] TAIL_PATTERN_DEF = 16'hBEAF;
    localparam int          STAT_W           = 16;

    // Statistics stick at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap timer for the frame word assembler. Only built when
// FRAME_GAP_TIMEOUT_EN is defined.
//   div_8_clk  : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   collecting : assembler is in the middle of a frame
//   byte_valid : a byte is being accepted this cycle
//   timeout    : this cycle is the TIMEOUT_CYCLES-th consecutive idle cycle of a frame
// Implemented as a down-counter reloaded on every byte (and outside a frame);
// the terminal count of 1 marks the last idle cycle allowed.
module frame_gap_timer #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic div_8_clk,
    input  logic rst_n,
    input  logic collecting,
    input  logic byte_valid,
    output logic timeout
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] RELOAD = GW'(TIMEOUT_CYCLES);

    logic [GW-1:0] gap_q, gap_d;

    always_comb begin
        gap_d   = gap_q;
        timeout = 1'b0;
        if (!collecting || byte_valid) begin
            gap_d = RELOAD;
        end else if (gap_q == GW'(1)) begin
            timeout = 1'b1;
            gap_d   = RELOAD;
        end else begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) gap_q <= RELOAD;
        else        gap_q <= gap_d;
    end

endmodule

// File: rtl/frame_word_assembler.sv
// Frame word assembler: hunts a sync nibble in a byte stream, collects
// BYTES_PER_WORD bytes MSB first, optionally checks the low 16 bits against a
// tail pattern, and reports the result with one-cycle strobes and statistics.
//   div_8_clk      : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   data_in        : input byte, sampled only when data_in_valid is high
//   data_in_valid  : byte qualifier
//   data_out       : last good word
//   data_out_valid : one-cycle pulse, data_out was updated
//   frame_err      : one-cycle pulse, a frame was rejected
//   good_cnt       : good frames, saturating
//   err_cnt        : rejected frames, saturating
// Optional macro FRAME_GAP_TIMEOUT_EN: abandon a frame after TIMEOUT_CYCLES
// consecutive idle cycles (counted as a rejected frame).
//
// state   | meaning
// IDLE    | hunting for a byte whose high nibble is the sync nibble
// COLLECT | frame started, shifting in the remaining bytes
module frame_word_assembler
    import frame_asm_pkg::*;
#(
    parameter int          BYTES_PER_WORD = 4,
    parameter logic [3:0]  SYNC_NIBBLE    = SYNC_NIBBLE_DEF,
    parameter logic [15:0] TAIL_PATTERN   = TAIL_PATTERN_DEF,
    parameter int          TAIL_CHECK     = 1,
    parameter int          TIMEOUT_CYCLES = 8
) (
    input  logic                        div_8_clk,
    input  logic                        rst_n,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic [8*BYTES_PER_WORD-1:0] data_out,
    output logic                        data_out_valid,
    output logic                        frame_err,
    output logic [STAT_W-1:0]           good_cnt,
    output logic [STAT_W-1:0]           err_cnt
);

    localparam int WORD_W  = 8 * BYTES_PER_WORD;
    localparam int SHIFT_W = WORD_W - 8;
    localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_WORD - 1);

    // Fewer than 3 bytes would let the sync header and the tail overlap.
    if (BYTES_PER_WORD < 3 || BYTES_PER_WORD > 8) begin : g_bad_bpw
        $fatal(1, "frame_word_assembler: BYTES_PER_WORD must be 3..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $fatal(1, "frame_word_assembler: TIMEOUT_CYCLES must be >= 1");
    end

    state_e              state_q, state_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [WORD_W-1:0]   data_out_q, data_out_d;
    logic                data_out_valid_q, data_out_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [STAT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [STAT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WORD_W-1:0]   word;
    logic                tail_ok;
    logic                gap_timeout;

`ifdef FRAME_GAP_TIMEOUT_EN
    frame_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .div_8_clk  (div_8_clk),
        .rst_n      (rst_n),
        .collecting (state_q == COLLECT),
        .byte_valid (data_in_valid),
        .timeout    (gap_timeout)
    );
`else
    assign gap_timeout = 1'b0;
`endif

    assign word    = {shift_q, data_in};
    assign tail_ok = (TAIL_CHECK == 0) || (word[15:0] == TAIL_PATTERN);

    always_comb begin
        state_d          = state_q;
        byte_cnt_d       = byte_cnt_q;
        shift_d          = shift_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        frame_err_d      = 1'b0;
        good_cnt_d       = good_cnt_q;
        err_cnt_d        = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (data_in_valid && data_in[7:4] == SYNC_NIBBLE) begin
                    shift_d    = SHIFT_W'(data_in);
                    byte_cnt_d = 4'd1;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                // Sync nibbles inside a frame are plain data; no resync.
                if (data_in_valid) begin
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d    = IDLE;
                        byte_cnt_d = 4'd0;
                        if (tail_ok) begin
                            data_out_d       = word;
                            data_out_valid_d = 1'b1;
                            good_cnt_d       = sat_inc(good_cnt_q);
                        end else begin
                            frame_err_d = 1'b1;
                            err_cnt_d   = sat_inc(err_cnt_q);
                        end
                    end else begin
                        shift_d    = {shift_q[SHIFT_W-9:0], data_in};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end else if (gap_timeout) begin
                    state_d     = IDLE;
                    byte_cnt_d  = 4'd0;
                    frame_err_d = 1'b1;
                    err_cnt_d   = sat_inc(err_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            byte_cnt_q       <= 4'd0;
            shift_q          <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            frame_err_q      <= 1'b0;
            good_cnt_q       <= '0;
            err_cnt_q        <= '0;
        end else begin
            state_q          <= state_d;
            byte_cnt_q       <= byte_cnt_d;
            shift_q          <= shift_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            frame_err_q      <= frame_err_d;
            good_cnt_q       <= good_cnt_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_err      = frame_err_q;
    assign good_cnt       = good_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_frame_word_assembler.sv
// Self-checking bench for frame_word_assembler (BYTES_PER_WORD=4, defaults).
// A queue-based frame model predicts every output each cycle; directed
// sequences also carry hand-computed literal expectations.
module tb_frame_word_assembler;

    localparam int BPW     = 4;
    localparam int TIMEOUT = 8;

    logic        div_8_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic [7:0]  data_in   = 8'h00;
    logic        data_in_valid = 1'b0;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        frame_err;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    frame_word_assembler #(
        .BYTES_PER_WORD (BPW),
        .SYNC_NIBBLE    (4'hA),
        .TAIL_PATTERN   (16'hBEAF),
        .TAIL_CHECK     (1),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .div_8_clk      (div_8_clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_err      (frame_err),
        .good_cnt       (good_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 div_8_clk = ~div_8_clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: a frame is a list of accepted bytes.
    logic [7:0]  frame_q[$];
    int          gap;
    logic [31:0] m_data;
    logic        m_dv, m_ferr;
    logic [15:0] m_good, m_err;

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q.delete();
            gap = 0; m_data = '0; m_dv = 0; m_ferr = 0; m_good = '0; m_err = '0;
        end else begin
            logic [31:0] w;
            m_dv = 0; m_ferr = 0;
            if (frame_q.size() == 0) begin
                if (data_in_valid && data_in[7:4] == 4'hA) begin
                    frame_q.push_back(data_in);
                    gap = 0;
                end
            end else if (data_in_valid) begin
                frame_q.push_back(data_in);
                gap = 0;
                if (frame_q.size() == BPW) begin
                    w = '0;
                    foreach (frame_q[i]) w = (w << 8) | 32'(frame_q[i]);
                    if (w[15:0] == 16'hBEAF) begin
                        m_data = w; m_dv = 1; m_good = sat(m_good);
                    end else begin
                        m_ferr = 1; m_err = sat(m_err);
                    end
                    frame_q.delete();
                end
            end else begin
`ifdef FRAME_GAP_TIMEOUT_EN
                gap++;
                if (gap == TIMEOUT) begin
                    frame_q.delete();
                    gap = 0;
                    m_ferr = 1; m_err = sat(m_err);
                end
`endif
            end
        end
    end

    // Compare process: every falling edge once the bench is out of power-up.
    always @(negedge div_8_clk) begin
        if (chk_en) begin
            chk("data_out", 64'(data_out), 64'(m_data));
            chk("data_out_valid", 64'(data_out_valid), 64'(m_dv));
            chk("frame_err", 64'(frame_err), 64'(m_ferr));
            chk("good_cnt", 64'(good_cnt), 64'(m_good));
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
        end
    end

    task automatic send(input logic v, input logic [7:0] b);
        @(negedge div_8_clk); #1;
        data_in_valid = v;
        data_in       = b;
    endtask

    task automatic do_reset();
        @(negedge div_8_clk); #1;
        rst_n = 1'b0; data_in_valid = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge div_8_clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_list(input logic [7:0] bytes[]);
        foreach (bytes[i]) send(1'b1, bytes[i]);
    endtask

    initial begin
        repeat (3) @(negedge div_8_clk);
        #1;
        chk("reset_data_out", 64'(data_out), 64'h0);
        chk("reset_strobes", 64'({data_out_valid, frame_err}), 64'h0);
        chk("reset_counts", 64'({good_cnt, err_cnt}), 64'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Good frame, strobe one cycle after the last byte's edge.
        send_list('{8'hA5, 8'h12, 8'hBE, 8'hAF});
        send(1'b0, 8'h00);
        chk("t1_dv", 64'(data_out_valid), 64'h1);
        chk("t1_data", 64'(data_out), 64'hA512BEAF);
        chk("t1_good", 64'(good_cnt), 64'h1);
        send(1'b0, 8'h00);
        chk("t1_dv_pulse", 64'(data_out_valid), 64'h0);

        // Bad tail.
        do_reset();
        send_list('{8'hA5, 8'h12, 8'hBE, 8'h00});
        send(1'b0, 8'h00);
        chk("t2_ferr", 64'(frame_err), 64'h1);
        chk("t2_data", 64'(data_out), 64'h0);
        chk("t2_err", 64'(err_cnt), 64'h1);
        chk("t2_good", 64'(good_cnt), 64'h0);
        send(1'b0, 8'h00);
        chk("t2_ferr_pulse", 64'(frame_err), 64'h0);

        // Leading junk, then a frame with a 3-cycle gap.
        do_reset();
        send_list('{8'h33, 8'h7F, 8'hA0, 8'h00});
        repeat (3) send(1'b0, 8'hA7);
        send_list('{8'hBE, 8'hAF});
        send(1'b0, 8'h00);
        chk("t3_data", 64'(data_out), 64'hA000BEAF);
        chk("t3_dv", 64'(data_out_valid), 64'h1);

        // Back-to-back frames.
        do_reset();
        send_list('{8'hA1, 8'h11, 8'hBE, 8'hAF, 8'hA2});
        chk("t4_dv1", 64'(data_out_valid), 64'h1);
        chk("t4_data1", 64'(data_out), 64'hA111BEAF);
        send_list('{8'h22, 8'hBE, 8'hAF});
        chk("t4_gap_dv", 64'(data_out_valid), 64'h0);
        send(1'b0, 8'h00);
        chk("t4_dv2", 64'(data_out_valid), 64'h1);
        chk("t4_data2", 64'(data_out), 64'hA222BEAF);
        chk("t4_good", 64'(good_cnt), 64'h2);

        // Reset mid-frame.
        send_list('{8'hA5, 8'h12});
        do_reset();
        chk("t5_rst", 64'({data_out, data_out_valid, frame_err, good_cnt, err_cnt}), 64'h0);
        send_list('{8'hA6, 8'h00, 8'hBE, 8'hAF});
        send(1'b0, 8'h00);
        chk("t5_data", 64'(data_out), 64'hA600BEAF);
        chk("t5_good", 64'(good_cnt), 64'h1);

`ifdef FRAME_GAP_TIMEOUT_EN
        do_reset();
        send_list('{8'hA5, 8'h12});
        repeat (TIMEOUT) send(1'b0, 8'h00);
        send(1'b1, 8'hBE);
        chk("t6_ferr", 64'(frame_err), 64'h1);
        chk("t6_err", 64'(err_cnt), 64'h1);
        send(1'b1, 8'hAF);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        chk("t6_no_good", 64'({good_cnt, data_out}), 64'h0);
        // Seven idle cycles is still within the allowed gap.
        send_list('{8'hA9, 8'h12});
        repeat (TIMEOUT - 1) send(1'b0, 8'h00);
        send_list('{8'hBE, 8'hAF});
        send(1'b0, 8'h00);
        chk("t6_gap7_data", 64'(data_out), 64'hA912BEAF);
`endif

        // Randomised traffic with sync/tail-biased bytes and occasional long gaps.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)       b = {4'hA, 4'($urandom_range(0, 15))};
            else if (sel < 5)  b = 8'hBE;
            else if (sel < 7)  b = 8'hAF;
            else               b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0)
                repeat ($urandom_range(6, 10)) send(1'b0, 8'($urandom_range(0, 255)));
            if (i == 1500) do_reset();
            send($urandom_range(0, 3) != 0, b);
        end
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
